// File: rtl/uc_collector_if.sv
// Handshake bundle between the per-engine unit-clause producers, the collector and the arbiter.
`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 255
`endif

interface uc_collector_if #(
    parameter int NUM_ENG = `NUM_ENGINE,
    parameter int LW      = $clog2(`LIT_IDX_MAX) + 1
);
    logic [NUM_ENG-1:0]         eng_push;
    logic [NUM_ENG-1:0][LW-1:0] eng_lit;
    logic [NUM_ENG-1:0]         engmask;
    logic                       uca_pop;
    logic                       flush;
    logic signed [LW-1:0]       eng2uca;
    logic                       eng2uca_valid;
    logic                       eng2uca_empty;
    logic [NUM_ENG-1:0]         eng2uca_full;
    logic [NUM_ENG-1:0]         overflow;

    modport master (
        output eng_push, eng_lit, engmask, uca_pop, flush,
        input  eng2uca, eng2uca_valid, eng2uca_empty, eng2uca_full, overflow
    );

    modport slave (
        input  eng_push, eng_lit, engmask, uca_pop, flush,
        output eng2uca, eng2uca_valid, eng2uca_empty, eng2uca_full, overflow
    );
endinterface

// File: rtl/uc_collector.sv
// Unit-clause collector: one circular FIFO per engine, head of the lowest-selected engine
// presented to the arbiter; full flags double as engine back-pressure.
`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 255
`endif

module uc_collector #(
    parameter int NUM_ENG = `NUM_ENGINE,
    parameter int LIT_MAX = `LIT_IDX_MAX,
    parameter int DEPTH   = 4
) (
    input logic           clk,
    input logic           rst,
    uc_collector_if.slave bus
);
    localparam int LW = $clog2(LIT_MAX) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    logic [LW-1:0]      mem    [NUM_ENG][DEPTH];
    logic [PW-1:0]      rd_ptr [NUM_ENG];
    logic [PW-1:0]      wr_ptr [NUM_ENG];
    logic [CW-1:0]      count  [NUM_ENG];
    logic [CW-1:0]      count_nxt [NUM_ENG];
    logic [NUM_ENG-1:0] full_q;
    logic [NUM_ENG-1:0] ovf_q;

    logic               sel_any;
    logic [SW-1:0]      sel_idx;
    logic               sel_empty;
    logic [LW-1:0]      head;
    logic [NUM_ENG-1:0] pop_hit;
    logic [NUM_ENG-1:0] push_ok;
    logic [NUM_ENG-1:0] push_drop;

    // Descending scan so the lowest set engmask bit is the last (winning) assignment.
    always_comb begin
        sel_any = 1'b0;
        sel_idx = '0;
        for (int unsigned i = NUM_ENG; i > 0; i--) begin
            if (bus.engmask[i-1]) begin
                sel_any = 1'b1;
                sel_idx = SW'(i - 1);
            end
        end
    end

    always_comb begin
        sel_empty = !sel_any || (count[sel_idx] == '0);
        head      = mem[sel_idx][rd_ptr[sel_idx]];
    end

    assign bus.eng2uca       = sel_empty ? '0 : $signed(head);
    assign bus.eng2uca_empty = sel_empty;
    assign bus.eng2uca_valid = !sel_empty;
    assign bus.eng2uca_full  = full_q;
    assign bus.overflow      = ovf_q;

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    always_comb begin
        pop_hit   = '0;
        push_ok   = '0;
        push_drop = '0;
        for (int unsigned i = 0; i < NUM_ENG; i++) begin
            pop_hit[i]   = !bus.flush && bus.uca_pop && !sel_empty && (sel_idx == SW'(i));
            push_ok[i]   = !bus.flush && bus.eng_push[i] && (bus.eng_lit[i] != '0)
                           && (!full_q[i] || pop_hit[i]);
            push_drop[i] = !bus.flush && bus.eng_push[i] && (bus.eng_lit[i] != '0)
                           && full_q[i] && !pop_hit[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_ENG; i++) begin
            count_nxt[i] = count[i];
            if (push_ok[i] && !pop_hit[i]) begin
                count_nxt[i] = count[i] + CW'(1);
            end else if (pop_hit[i] && !push_ok[i]) begin
                count_nxt[i] = count[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_ENG; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            full_q <= '0;
            ovf_q  <= '0;
        end else if (bus.flush) begin
            for (int unsigned i = 0; i < NUM_ENG; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            full_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_ENG; i++) begin
                if (pop_hit[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                if (push_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                count[i]  <= count_nxt[i];
                full_q[i] <= (count_nxt[i] == CW'(DEPTH));
                if (push_drop[i]) begin
                    ovf_q[i] <= 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_ENG; i++) begin
            if (rst && push_ok[i]) begin
                mem[i][wr_ptr[i]] <= bus.eng_lit[i];
            end
        end
    end
endmodule

// File: tb/tb_uc_collector.sv
// Directed plus randomized bench for uc_collector with a per-engine queue scoreboard.
module tb_uc_collector;
    localparam int NE  = 4;
    localparam int LW  = 9;
    localparam int DEP = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   known  = 1'b0;
    int   sb [NE][$];
    logic [NE-1:0] ovf_m = '0;

    always #5 clk = ~clk;

    uc_collector_if #(.NUM_ENG(NE), .LW(LW)) bus ();

    uc_collector #(.NUM_ENG(NE), .LIT_MAX(255), .DEPTH(DEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.eng_push = '0;
        bus.eng_lit  = '0;
        bus.engmask  = '0;
        bus.uca_pop  = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic push(input int e, input int lit);
        bus.eng_push    = '0;
        bus.eng_push[e] = 1'b1;
        bus.eng_lit[e]  = LW'(lit);
    endtask

    // Compare outputs against the scoreboard before the edge, then apply the edge to the model.
    task automatic tick();
        int sel;
        int popped;
        int lit;
        bit has;
        logic [NE-1:0] exp_full;
        @(negedge clk);
        sel = -1;
        for (int i = NE - 1; i >= 0; i--) if (bus.engmask[i]) sel = i;
        has = (sel >= 0) && (sb[sel].size() > 0);
        exp_full = '0;
        for (int i = 0; i < NE; i++) exp_full[i] = (sb[i].size() == DEP);
        if (known) begin
            chk("eng2uca", $signed(bus.eng2uca), has ? sb[sel][0] : 0);
            chk("valid", bus.eng2uca_valid, has);
            chk("empty", bus.eng2uca_empty, !has);
            chk("full", bus.eng2uca_full, exp_full);
            chk("overflow", bus.overflow, ovf_m);
        end
        if (!rst) begin
            for (int i = 0; i < NE; i++) sb[i].delete();
            ovf_m = '0;
            known = 1'b1;
        end else if (bus.flush) begin
            for (int i = 0; i < NE; i++) sb[i].delete();
        end else begin
            popped = -1;
            if (bus.uca_pop && has) begin
                void'(sb[sel].pop_front());
                popped = sel;
            end
            for (int i = 0; i < NE; i++) begin
                lit = int'($signed(bus.eng_lit[i]));
                if (bus.eng_push[i] && lit != 0) begin
                    if (sb[i].size() < DEP || popped == i) sb[i].push_back(lit);
                    else ovf_m[i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        bus.eng_push = '1;
        for (int i = 0; i < NE; i++) bus.eng_lit[i] = LW'(7);
        bus.uca_pop = 1'b1;
        tick();
        tick();
        idle();
        bus.engmask = 4'b0100;
        #1;
        chk("rst_lit", $signed(bus.eng2uca), 0);
        chk("rst_valid", bus.eng2uca_valid, 0);
        chk("rst_empty", bus.eng2uca_empty, 1);
        chk("rst_full", bus.eng2uca_full, 0);
        chk("rst_ovf", bus.overflow, 0);
        rst = 1'b1;
        idle();

        // basic ordering on engine 2
        push(2, 5);
        tick();
        push(2, -7);
        tick();
        idle();
        bus.engmask = 4'b0100;
        #1;
        chk("ord_first", $signed(bus.eng2uca), 5);
        bus.uca_pop = 1'b1;
        tick();
        chk("ord_second", $signed(bus.eng2uca), -7);
        tick();
        chk("ord_empty", bus.eng2uca_empty, 1);
        idle();

        // full and overflow on engine 0
        for (int k = 1; k <= 5; k++) begin
            push(0, k);
            tick();
            if (k == 3) chk("full_after3", bus.eng2uca_full[0], 0);
            if (k == 4) chk("full_after4", bus.eng2uca_full[0], 1);
        end
        idle();
        chk("ovf0_set", bus.overflow[0], 1);
        bus.engmask = 4'b0001;
        bus.uca_pop = 1'b1;
        #1;
        chk("drain_first", $signed(bus.eng2uca), 1);
        repeat (4) tick();
        chk("drain_empty", bus.eng2uca_empty, 1);
        chk("drain_notfull", bus.eng2uca_full[0], 0);
        idle();

        // push and pop together on full engine 1
        for (int k = 11; k <= 14; k++) begin
            push(1, k);
            tick();
        end
        idle();
        chk("pp_full_before", bus.eng2uca_full[1], 1);
        push(1, 9);
        bus.engmask = 4'b0010;
        bus.uca_pop = 1'b1;
        tick();
        chk("pp_full_stays", bus.eng2uca_full[1], 1);
        chk("pp_no_ovf", bus.overflow[1], 0);
        idle();
        bus.engmask = 4'b0010;
        bus.uca_pop = 1'b1;
        repeat (3) tick();
        chk("pp_last", $signed(bus.eng2uca), 9);
        tick();
        chk("pp_empty", bus.eng2uca_empty, 1);
        idle();

        // masking
        push(1, 21);
        tick();
        push(2, 22);
        tick();
        idle();
        bus.uca_pop = 1'b1;
        tick();
        chk("mask0_empty", bus.eng2uca_empty, 1);
        chk("mask0_lit", $signed(bus.eng2uca), 0);
        bus.uca_pop = 1'b0;
        bus.engmask = 4'b0110;
        #1;
        chk("mask0110_sel", $signed(bus.eng2uca), 21);
        bus.uca_pop = 1'b1;
        tick();
        chk("mask0110_after", bus.eng2uca_empty, 1);
        bus.engmask = 4'b0100;
        #1;
        chk("e2_kept", $signed(bus.eng2uca), 22);
        idle();

        // zero literal, including against a full FIFO
        push(3, 0);
        tick();
        bus.engmask = 4'b1000;
        #1;
        chk("zero_empty", bus.eng2uca_empty, 1);
        idle();
        for (int k = 31; k <= 34; k++) begin
            push(3, k);
            tick();
        end
        push(3, 0);
        tick();
        chk("zero_full_ovf", bus.overflow[3], 0);
        chk("zero_full_kept", bus.eng2uca_full[3], 1);

        // simultaneous pushes stay isolated
        idle();
        bus.eng_push   = 4'b0011;
        bus.eng_lit[0] = LW'(41);
        bus.eng_lit[1] = LW'(-42);
        tick();
        idle();
        bus.engmask = 4'b0010;
        #1;
        chk("iso_e1", $signed(bus.eng2uca), -42);

        // flush with a same-cycle push
        idle();
        push(0, 3);
        bus.flush   = 1'b1;
        bus.uca_pop = 1'b1;
        bus.engmask = 4'b0001;
        tick();
        idle();
        for (int e = 0; e < NE; e++) begin
            bus.engmask = 4'(1 << e);
            #1;
            chk("flush_empty", bus.eng2uca_empty, 1);
        end
        chk("flush_full", bus.eng2uca_full, 0);
        chk("flush_ovf_kept", bus.overflow, 4'b0001);
        idle();

        // reset mid-stream
        push(1, 50);
        tick();
        push(2, 51);
        tick();
        rst = 1'b0;
        bus.engmask = 4'b0010;
        bus.uca_pop = 1'b1;
        tick();
        chk("rst2_lit", $signed(bus.eng2uca), 0);
        chk("rst2_valid", bus.eng2uca_valid, 0);
        chk("rst2_empty", bus.eng2uca_empty, 1);
        chk("rst2_full", bus.eng2uca_full, 0);
        chk("rst2_ovf", bus.overflow, 0);
        rst = 1'b1;
        idle();
        tick();

        // randomized traffic against the scoreboard
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int i = 0; i < NE; i++) begin
                bus.eng_push[i] = ($urandom_range(0, 2) == 0);
                bus.eng_lit[i]  = LW'(int'($urandom_range(0, 40)) - 20);
            end
            case ($urandom_range(0, 5))
                0: bus.engmask = 4'b0000;
                1: bus.engmask = 4'b0001;
                2: bus.engmask = 4'b0010;
                3: bus.engmask = 4'b0100;
                4: bus.engmask = 4'b1000;
                default: bus.engmask = 4'($urandom_range(0, 15));
            endcase
            bus.uca_pop = ($urandom_range(0, 2) != 0);
            bus.flush   = ($urandom_range(0, 40) == 0);
            tick();
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
